// File: rtl/dtcore32_scoreboard_hazard_unit_if.sv
// Hazard unit bundle: pipeline-side inputs, stall/flush/forward outputs.
// master = pipeline control, slave = hazard unit.
interface dtcore32_scoreboard_hazard_unit_if #(
  parameter int NUM_FWD_STAGES = 4,
  parameter int LAT_W          = 3,
  parameter int FSEL_W         = $clog2(NUM_FWD_STAGES + 1)
);
  logic                          ID_valid_i;
  logic [4:0]                    ID_rs1_addr_i;
  logic [4:0]                    ID_rs2_addr_i;
  logic [4:0]                    ID_rd_addr_i;
  logic [LAT_W-1:0]              ID_lat_i;
  logic                          ID_issue_i;
  logic [4:0]                    EX_rs1_addr_i;
  logic [4:0]                    EX_rs2_addr_i;
  logic [5*NUM_FWD_STAGES-1:0]   FWD_rd_addr_i;
  logic [NUM_FWD_STAGES-1:0]     FWD_valid_i;
  logic                          EX_pc_src_i;
  logic [NUM_FWD_STAGES+1:0]     trap_valid_i;
  logic [FSEL_W-1:0]             EX_forward_a_o;
  logic [FSEL_W-1:0]             EX_forward_b_o;
  logic [NUM_FWD_STAGES+1:0]     flush_o;
  logic                          IF_stall_o;
  logic                          ID_stall_o;
  logic [31:0]                   stall_cycles_o;

  modport master (
    output ID_valid_i, ID_rs1_addr_i, ID_rs2_addr_i,
    output ID_rd_addr_i, ID_lat_i, ID_issue_i,
    output EX_rs1_addr_i, EX_rs2_addr_i,
    output FWD_rd_addr_i, FWD_valid_i,
    output EX_pc_src_i, trap_valid_i,
    input  EX_forward_a_o, EX_forward_b_o, flush_o,
    input  IF_stall_o, ID_stall_o, stall_cycles_o
  );

  modport slave (
    input  ID_valid_i, ID_rs1_addr_i, ID_rs2_addr_i,
    input  ID_rd_addr_i, ID_lat_i, ID_issue_i,
    input  EX_rs1_addr_i, EX_rs2_addr_i,
    input  FWD_rd_addr_i, FWD_valid_i,
    input  EX_pc_src_i, trap_valid_i,
    output EX_forward_a_o, EX_forward_b_o, flush_o,
    output IF_stall_o, ID_stall_o, stall_cycles_o
  );
endinterface

// File: rtl/dtcore32_scoreboard_hazard_unit.sv
// Latency-scoreboard hazard unit: stalls, N-stage forwarding, flush vector.
// Optional stall counter under DTCORE32_HAZARD_PERF_EN.
module dtcore32_scoreboard_hazard_unit #(
  parameter int NUM_FWD_STAGES = 4,
  parameter int MAX_LAT        = 4,
  parameter int LAT_W          = 3,
  parameter int FSEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  dtcore32_scoreboard_hazard_unit_if.slave hz
);

  localparam int NS = NUM_FWD_STAGES + 2;

  logic [31:0][LAT_W-1:0] cnt_q;
  logic                   trap_any;
  logic                   rs1_busy;
  logic                   rs2_busy;
  logic                   stall;
  logic                   set_en;
  logic [LAT_W-1:0]       lat_sat;
  logic [FSEL_W-1:0]      fwd_a;
  logic [FSEL_W-1:0]      fwd_b;
  logic [NS-1:0]          flush;

  assign trap_any = |hz.trap_valid_i;

  // Out-of-range latencies are clamped rather than trusted.
  assign lat_sat = (hz.ID_lat_i > LAT_W'(MAX_LAT))
                 ? LAT_W'(MAX_LAT) : hz.ID_lat_i;

  assign rs1_busy = (hz.ID_rs1_addr_i != 5'd0)
                  & (cnt_q[hz.ID_rs1_addr_i] != '0);
  assign rs2_busy = (hz.ID_rs2_addr_i != 5'd0)
                  & (cnt_q[hz.ID_rs2_addr_i] != '0);
  assign stall    = hz.ID_valid_i & (rs1_busy | rs2_busy);

  assign set_en = hz.ID_issue_i & ~stall & ~hz.EX_pc_src_i
                & ~trap_any & (hz.ID_rd_addr_i != 5'd0)
                & (lat_sat != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        if (r == 0 || trap_any)
          cnt_q[r] <= '0;
        else if (set_en && hz.ID_rd_addr_i == 5'(r))
          cnt_q[r] <= lat_sat;
        else if (cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - LAT_W'(1);
      end
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (hz.FWD_valid_i[k]
          && hz.FWD_rd_addr_i[5*k +: 5] == hz.EX_rs1_addr_i)
        fwd_a = FSEL_W'(k + 1);
      if (hz.FWD_valid_i[k]
          && hz.FWD_rd_addr_i[5*k +: 5] == hz.EX_rs2_addr_i)
        fwd_b = FSEL_W'(k + 1);
    end
    if (hz.EX_rs1_addr_i == 5'd0) fwd_a = '0;
    if (hz.EX_rs2_addr_i == 5'd0) fwd_b = '0;
  end

  always_comb begin
    logic acc;
    acc   = 1'b0;
    flush = '0;
    for (int j = NS - 1; j >= 1; j--) begin
      acc      = acc | hz.trap_valid_i[j];
      flush[j] = acc;
    end
    flush[1] = flush[1] | hz.EX_pc_src_i;
    // A stalled ID instruction is not yet the trapping one.
    flush[0] = (hz.trap_valid_i[0] & ~stall)
             | acc | hz.EX_pc_src_i;
  end

  assign hz.EX_forward_a_o = fwd_a;
  assign hz.EX_forward_b_o = fwd_b;
  assign hz.flush_o        = flush;
  assign hz.IF_stall_o     = stall;
  assign hz.ID_stall_o     = stall;

`ifdef DTCORE32_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_q <= '0;
    else if (stall)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign hz.stall_cycles_o = stall_cnt_q;
`else
  assign hz.stall_cycles_o = '0;
`endif

endmodule

// File: doc/dtcore32_scoreboard_hazard_unit.md
Name: dtcore32_scoreboard_hazard_unit

Overview:
- Parametrised next-generation hazard unit for the dtcore32 pipeline.
- Replaces the fixed load-use compare with a per-register latency scoreboard. Supports multi-cycle producers (loads, multiplier, future divider) of any latency up to MAX_LAT.
- Generalises EX forwarding to NUM_FWD_STAGES downstream stages with youngest-match priority.
- Generates trap/branch flush vectors for a pipeline of arbitrary depth. Sits beside the ID/EX pipeline registers.

Parameters:
- NUM_FWD_STAGES, 4, number of stages after EX that can forward (index 0 = MEM1, youngest).
- MAX_LAT, 4, largest producer latency in cycles (ID_lat_i range 0..MAX_LAT).
- LAT_W, 3, width of latency fields; must satisfy 2**LAT_W > MAX_LAT.
- FSEL_W, $clog2(NUM_FWD_STAGES+1), width of the forward-select outputs.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous reset, active-high.
- ID_valid_i  in  1  ID holds a real instruction.
- ID_rs1_addr_i  in  5  ID source 1.
- ID_rs2_addr_i  in  5  ID source 2.
- ID_rd_addr_i  in  5  ID destination.
- ID_lat_i  in  LAT_W  extra cycles until the ID result is forwardable; 0 = single-cycle ALU.
- ID_issue_i  in  1  ID instruction advances into EX this cycle, when not stalled.
- EX_rs1_addr_i  in  5  EX source 1.
- EX_rs2_addr_i  in  5  EX source 2.
- FWD_rd_addr_i  in  5*NUM_FWD_STAGES  packed stage destinations; stage k occupies bits [5k+4:5k].
- FWD_valid_i  in  NUM_FWD_STAGES  stage k writes rd and has its result available.
- EX_pc_src_i  in  1  taken branch/jump resolved in EX.
- trap_valid_i  in  NUM_FWD_STAGES+2  bit 0 = ID, bit 1 = EX, bit k+2 = forward stage k.
- EX_forward_a_o  out  FSEL_W  0 = no forward; k+1 = take stage k.
- EX_forward_b_o  out  FSEL_W  same encoding, for rs2.
- flush_o  out  NUM_FWD_STAGES+2  per-stage flush; same bit order as trap_valid_i.
- IF_stall_o  out  1  hold PC.
- ID_stall_o  out  1  hold the IF/ID register.
- stall_cycles_o  out  32  stall performance counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high): all scoreboard counters cleared to 0; stall_cycles_o = 0. All outputs are combinational from the cleared state and inputs. With no inputs asserted: stalls = 0, flush_o = 0, forward selects = 0.
- Scoreboard: cnt[r] is an LAT_W-bit counter for r = 1..31. Register x0 has no counter and always reads as 0.
- Set: when ID_issue_i & ~ID_stall_o & ~EX_pc_src_i & ~|trap_valid_i & (ID_rd_addr_i != 0) & (ID_lat_i != 0), load cnt[ID_rd_addr_i] <= ID_lat_i.
- Set beats decrement on the same register in the same cycle (WAW case: the newest producer wins).
- Decrement: every other cnt[r] != 0 decrements by 1 each cycle; counters saturate at 0.
- Trap clear: any trap_valid_i bit set clears all counters on the next edge, because the pipeline is being drained.
- Stall (combinational): stall = ID_valid_i & ((rs1 != 0 & cnt[rs1] != 0) | (rs2 != 0 & cnt[rs2] != 0)). IF_stall_o = ID_stall_o = stall.
- Load-use timing: a load issued with ID_lat_i = 1 stalls a dependent ID instruction exactly 1 cycle.
- Forwarding (combinational): EX_forward_a_o = (lowest k with FWD_valid_i[k] & FWD rd[k] == EX_rs1_addr_i & EX_rs1_addr_i != 0) + 1, else 0. EX_forward_b_o is the same for rs2. The youngest stage wins.
- Flush: flush_o[j] = OR of trap_valid_i[i] for i >= j, except bit 0. A trap in stage i flushes stage i and every younger stage.
- Flush bit 0 (ID) additionally requires: ID term = (trap_valid_i[0] & ~ID_stall_o) | OR(trap_valid_i[i>=1]) | EX_pc_src_i.
- EX_pc_src_i also sets flush_o[1].
- Simultaneous stall and flush: flush outputs still assert; the stall output is unaffected.

Optional Feature:
- Macro: DTCORE32_HAZARD_PERF_EN.
- Defined: stall_cycles_o is a 32-bit counter.
  - Increments each cycle ID_stall_o = 1.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared by rst_i.
- Undefined: stall_cycles_o is tied to 0 and no counter flops are generated.

Test Plan:
- Load-use: issue rd = 5, lat = 1; next cycle ID rs1 = 5 -> ID_stall_o = 1 for exactly 1 cycle, then 0.
- Multi-cycle multiply: issue rd = 7, lat = 3; ID rs2 = 7 -> stall for 3 cycles. The same case with rs2 = 0 never stalls.
- WAW overwrite: issue rd = 9 lat = 4, then two cycles later rd = 9 lat = 1. cnt[9] reloads to 1, so a dependent instruction stalls 1 cycle, not 2.
- Forward priority: EX_rs1 = 3; stage 0 and stage 2 both rd = 3 and valid -> EX_forward_a_o = 1. With stage 0 invalid -> 3. With EX_rs1 = 0 -> 0.
- Trap in stage 1 (trap_valid_i = 0b001000 with NUM_FWD_STAGES = 4) -> flush_o = 0b001111; all counters are 0 the next cycle. EX_pc_src_i alone -> flush_o = 0b000011.
- Reset mid-stall: cnt[5] = 3 and stalling; assert rst_i asynchronously -> ID_stall_o = 0 immediately and stall_cycles_o = 0 (perf build).
